// File: rtl/stack_controller_if.sv
// Bus bundle between core decode, the stack sequencer and its stack RAM.
// Handshake: there is no valid/ready pair. op is a per-cycle command that
// is always accepted on the next rising clock edge; NOP (00) means idle.
// RAM read is asynchronous (ram_read_data follows ram_read_address in the
// same cycle). A RAM write takes effect on the rising edge when
// ram_write_enable is high.
// Modports: master = core side (drives op/din/clear_errors) and the RAM
// model (drives ram_read_data); slave = the stack_controller.
`ifndef WIDTH
`define WIDTH 16
`endif

interface stack_controller_if #(parameter int DEPTH = 4);
  logic [1:0]        op;
  logic [`WIDTH-1:0] din;
  logic              clear_errors;
  logic [`WIDTH-1:0] top;
  logic [`WIDTH-1:0] next;
  logic [DEPTH:0]    depth;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;
  logic [DEPTH-1:0]  ram_read_address;
  logic [`WIDTH-1:0] ram_read_data;
  logic              ram_write_enable;
  logic [DEPTH-1:0]  ram_write_address;
  logic [`WIDTH-1:0] ram_write_data;

  modport master (
    output op, din, clear_errors, ram_read_data,
    input  top, next, depth, empty, full, overflow, underflow,
    input  ram_read_address, ram_write_enable, ram_write_address, ram_write_data
  );

  modport slave (
    input  op, din, clear_errors, ram_read_data,
    output top, next, depth, empty, full, overflow, underflow,
    output ram_read_address, ram_write_enable, ram_write_address, ram_write_data
  );
endinterface

// File: rtl/stack_controller.sv
// stack_controller: sequencer for one stack RAM. Holds the stack pointer,
// the cached top-of-stack register T and the occupancy count, and turns
// PUSH / POP / REPL2 ops into RAM port activity. N comes straight from the
// asynchronous RAM read at sp.
// Optional feature macro: STACK_GUARD_EN. When defined, illegal ops are
// suppressed and flagged in sticky overflow/underflow flags. When not
// defined, every op executes, sp wraps, count saturates and the flags
// read as 0.
`ifndef WIDTH
`define WIDTH 16
`endif

module stack_controller #(
  parameter int DEPTH = 4
) (
  input logic           clock,
  input logic           reset,
  stack_controller_if.slave bus
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_REPL2 = 2'b11;

  // Capacity counts the top register on top of the 2**DEPTH RAM slots.
  localparam logic [DEPTH:0]   CAP_CNT = (DEPTH+1)'((2 ** DEPTH) + 1);
  localparam logic [DEPTH:0]   CNT_ONE = (DEPTH+1)'(1);
  localparam logic [DEPTH:0]   CNT_TWO = (DEPTH+1)'(2);
  localparam logic [DEPTH-1:0] SP_ONE  = DEPTH'(1);

  logic [DEPTH-1:0]  sp;
  logic [`WIDTH-1:0] top_q;
  logic [DEPTH:0]    count;

  logic is_push, is_pop, is_repl;
  logic cnt_full, cnt_zero;
  logic push_go, pop_go, repl_go;

  // Decode the per-cycle op.
  always_comb begin
    is_push = 1'b0;
    is_pop  = 1'b0;
    is_repl = 1'b0;
    case (bus.op)
      OP_NOP:   ;
      OP_PUSH:  is_push = 1'b1;
      OP_POP:   is_pop  = 1'b1;
      OP_REPL2: is_repl = 1'b1;
      default:  ;
    endcase
  end

  assign cnt_full = (count == CAP_CNT);
  assign cnt_zero = (count == '0);

`ifdef STACK_GUARD_EN
  logic ovf_q, unf_q;
  logic push_bad, pop_bad, repl_bad;

  assign push_bad = is_push & cnt_full;
  assign pop_bad  = is_pop  & cnt_zero;
  assign repl_bad = is_repl & (count < CNT_TWO);

  assign push_go  = is_push & ~push_bad;
  assign pop_go   = is_pop  & ~pop_bad;
  assign repl_go  = is_repl & ~repl_bad;

  // Sticky error flags; an error in the same cycle beats clear_errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push_bad)
        ovf_q <= 1'b1;
      else if (bus.clear_errors)
        ovf_q <= 1'b0;
      if (pop_bad | repl_bad)
        unf_q <= 1'b1;
      else if (bus.clear_errors)
        unf_q <= 1'b0;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  // Without guarding every op runs; clear_errors has nothing to clear.
  logic unused_clear;
  assign unused_clear  = bus.clear_errors;

  assign push_go       = is_push;
  assign pop_go        = is_pop;
  assign repl_go       = is_repl;
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  // Stack pointer, top register and occupancy count.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp    <= '0;
      top_q <= '0;
      count <= '0;
    end else if (push_go) begin
      sp    <= sp + SP_ONE;
      top_q <= bus.din;
      if (!cnt_full)
        count <= count + CNT_ONE;
    end else if (pop_go) begin
      sp    <= sp - SP_ONE;
      top_q <= bus.ram_read_data;
      if (!cnt_zero)
        count <= count - CNT_ONE;
    end else if (repl_go) begin
      sp    <= sp - SP_ONE;
      top_q <= bus.din;
      if (!cnt_zero)
        count <= count - CNT_ONE;
    end
  end

  // A push spills the old T into the slot above sp. From empty this
  // writes a stale T, which is harmless since count marks it invalid.
  assign bus.ram_write_enable  = push_go & ~reset;
  assign bus.ram_write_address = sp + SP_ONE;
  assign bus.ram_write_data    = top_q;
  assign bus.ram_read_address  = sp;

  assign bus.top   = top_q;
  assign bus.next  = bus.ram_read_data;
  assign bus.depth = count;
  assign bus.empty = cnt_zero;
  assign bus.full  = cnt_full;

endmodule

// File: tb/tb_stack_controller.sv
// Testbench for stack_controller (DEPTH=4). Works with or without
// STACK_GUARD_EN defined; expectations follow the selected behaviour.
`ifndef WIDTH
`define WIDTH 16
`endif

module tb_stack_controller;
  localparam int DEPTH = 4;
  localparam int W     = `WIDTH;
  localparam int SLOTS = 2 ** DEPTH;
  localparam int CAP   = SLOTS + 1;
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [1:0] NOP   = 2'b00;
  localparam logic [1:0] PUSH  = 2'b01;
  localparam logic [1:0] POP   = 2'b10;
  localparam logic [1:0] REPL2 = 2'b11;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  stack_controller_if #(.DEPTH(DEPTH)) bus ();

  stack_controller #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Stack RAM model: asynchronous read, synchronous write.
  logic [W-1:0] ram_mem [0:SLOTS-1];
  assign bus.ram_read_data = ram_mem[bus.ram_read_address];
  always @(posedge clock) begin
    if (bus.ram_write_enable)
      ram_mem[bus.ram_write_address] <= bus.ram_write_data;
  end

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [1:0] op, input logic [W-1:0] din,
                        input logic clr, input logic rst);
    @(negedge clock);
    bus.op           = op;
    bus.din          = din;
    bus.clear_errors = clr;
    reset            = rst;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    set_in(NOP, '0, 1'b0, 1'b1);
    tick();
    set_in(NOP, '0, 1'b0, 1'b1);
    tick();
  endtask

  // ---------------- reference model / scoreboard ----------------
  // exp_q holds the valid stack entries, oldest first; exp_q[$] is T.
  logic [W-1:0] exp_q[$];
  int           m_sp;
  logic [W-1:0] m_top;
  bit           m_top_known;
  bit           m_ovf, m_unf;

  task automatic model_reset();
    exp_q.delete();
    m_sp = 0;
    m_top = '0;
    m_top_known = 1'b1;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic rand_cycle(input int push_bias);
    int r, sz, new_cnt;
    logic [1:0] op;
    logic [W-1:0] din;
    logic clr;
    bit bad, exp_we;
    r   = $urandom_range(0, 99);
    if (r < push_bias) op = PUSH;
    else begin
      case (r % 3)
        0: op = NOP;
        1: op = POP;
        default: op = REPL2;
      endcase
    end
    din = W'($urandom);
    clr = ($urandom_range(0, 7) == 0);
    sz  = exp_q.size();
    bad = (op == PUSH && sz == CAP) || (op == POP && sz == 0) || (op == REPL2 && sz < 2);

    set_in(op, din, clr, 1'b0);
    #1;
    exp_we = (op == PUSH) && (!GUARD || !bad);
    check("rnd_we", 32'(bus.ram_write_enable), 32'(exp_we));
    if (exp_we) begin
      check("rnd_waddr", 32'(bus.ram_write_address), 32'((m_sp + 1) % SLOTS));
      if (m_top_known) check("rnd_wdata", 32'(bus.ram_write_data), 32'(m_top));
    end

    if (!GUARD || !bad) begin
      case (op)
        PUSH: begin
          exp_q.push_back(din);
          if (exp_q.size() > CAP) void'(exp_q.pop_front());
          m_sp = (m_sp + 1) % SLOTS;
          m_top = din;
          m_top_known = 1'b1;
        end
        POP: begin
          if (sz > 0) void'(exp_q.pop_back());
          m_sp = (m_sp + SLOTS - 1) % SLOTS;
          if (exp_q.size() > 0) begin
            m_top = exp_q[$];
            m_top_known = 1'b1;
          end else m_top_known = 1'b0;
        end
        REPL2: begin
          new_cnt = (sz > 0) ? sz - 1 : 0;
          if (exp_q.size() > 0) void'(exp_q.pop_back());
          if (exp_q.size() > 0) void'(exp_q.pop_back());
          if (new_cnt > 0) exp_q.push_back(din);
          m_sp = (m_sp + SLOTS - 1) % SLOTS;
          m_top = din;
          m_top_known = 1'b1;
        end
        default: ;
      endcase
    end
    if (GUARD) begin
      if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (bad && op == PUSH) m_ovf = 1'b1;
      if (bad && op != PUSH) m_unf = 1'b1;
    end

    tick();
    check("rnd_depth", 32'(bus.depth), 32'(exp_q.size()));
    check("rnd_empty", 32'(bus.empty), 32'(exp_q.size() == 0));
    check("rnd_full", 32'(bus.full), 32'(exp_q.size() == CAP));
    check("rnd_sp", 32'(bus.ram_read_address), 32'(m_sp));
    check("rnd_ovf", 32'(bus.overflow), 32'(m_ovf));
    check("rnd_unf", 32'(bus.underflow), 32'(m_unf));
    if (m_top_known) check("rnd_top", 32'(bus.top), 32'(m_top));
    if (exp_q.size() >= 2) check("rnd_next", 32'(bus.next), 32'(exp_q[$-1]));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] din;
    logic         rst;
    logic         exp_we;
    logic [W-1:0] exp_top;
    int           exp_depth;
    bit           chk_next;
    logic [W-1:0] exp_next;
  } vec_t;

  vec_t vecs [9];

  initial begin
    for (int i = 0; i < SLOTS; i++) ram_mem[i] = '0;
    bus.op = NOP;
    bus.din = '0;
    bus.clear_errors = 1'b0;

    // Reset state
    set_in(NOP, '0, 1'b0, 1'b1);
    #1;
    check("rst_we", 32'(bus.ram_write_enable), 32'd0);
    tick();
    check("rst_top", 32'(bus.top), 32'd0);
    check("rst_depth", 32'(bus.depth), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_unf", 32'(bus.underflow), 32'd0);
    check("rst_sp", 32'(bus.ram_read_address), 32'd0);

    vecs[0] = '{PUSH,  W'('h11), 1'b0, 1'b1, W'('h11), 1, 1'b0, W'(0)};
    vecs[1] = '{PUSH,  W'('h22), 1'b0, 1'b1, W'('h22), 2, 1'b1, W'('h11)};
    vecs[2] = '{PUSH,  W'('h33), 1'b0, 1'b1, W'('h33), 3, 1'b1, W'('h22)};
    vecs[3] = '{POP,   W'(0),    1'b0, 1'b0, W'('h22), 2, 1'b1, W'('h11)};
    vecs[4] = '{POP,   W'(0),    1'b0, 1'b0, W'('h11), 1, 1'b1, W'(0)};
    vecs[5] = '{NOP,   W'(0),    1'b1, 1'b0, W'(0),    0, 1'b0, W'(0)};
    vecs[6] = '{PUSH,  W'(5),    1'b0, 1'b1, W'(5),    1, 1'b0, W'(0)};
    vecs[7] = '{PUSH,  W'(7),    1'b0, 1'b1, W'(7),    2, 1'b1, W'(5)};
    vecs[8] = '{REPL2, W'(12),   1'b0, 1'b0, W'(12),   1, 1'b1, W'(0)};

    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].op, vecs[i].din, 1'b0, vecs[i].rst);
      #1;
      check($sformatf("tbl%0d_we", i), 32'(bus.ram_write_enable), 32'(vecs[i].exp_we));
      tick();
      check($sformatf("tbl%0d_top", i), 32'(bus.top), 32'(vecs[i].exp_top));
      check($sformatf("tbl%0d_depth", i), 32'(bus.depth), 32'(vecs[i].exp_depth));
      if (vecs[i].chk_next)
        check($sformatf("tbl%0d_next", i), 32'(bus.next), 32'(vecs[i].exp_next));
      if (i == 4) begin
        check("tbl_ram1", 32'(ram_mem[1]), 32'h00);
        check("tbl_ram2", 32'(ram_mem[2]), 32'h11);
      end
    end

    // Fill to capacity, then one push too many
    do_reset();
    for (int i = 0; i < CAP; i++) begin
      set_in(PUSH, W'('h100 + i), 1'b0, 1'b0);
      tick();
    end
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_depth", 32'(bus.depth), 32'(CAP));
    check("fill_top", 32'(bus.top), 32'h110);
    set_in(PUSH, W'('hBEEF), 1'b0, 1'b0);
    #1;
`ifdef STACK_GUARD_EN
    check("ovf_we", 32'(bus.ram_write_enable), 32'd0);
    tick();
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_depth", 32'(bus.depth), 32'(CAP));
    check("ovf_top", 32'(bus.top), 32'h110);
    set_in(NOP, '0, 1'b1, 1'b0);
    tick();
    check("ovf_clear", 32'(bus.overflow), 32'd0);
`else
    check("wrap_we", 32'(bus.ram_write_enable), 32'd1);
    tick();
    check("wrap_ovf", 32'(bus.overflow), 32'd0);
    check("wrap_depth", 32'(bus.depth), 32'(CAP));
    check("wrap_top", 32'(bus.top), 32'hBEEF);
`endif

    // Underflow corners
    do_reset();
    set_in(POP, '0, 1'b0, 1'b0);
    tick();
    check("unf_pop_depth", 32'(bus.depth), 32'd0);
`ifdef STACK_GUARD_EN
    check("unf_pop_flag", 32'(bus.underflow), 32'd1);
    check("unf_pop_sp", 32'(bus.ram_read_address), 32'd0);
    set_in(NOP, '0, 1'b1, 1'b0);
    tick();
    check("unf_clear", 32'(bus.underflow), 32'd0);
`else
    check("unf_pop_flag", 32'(bus.underflow), 32'd0);
    check("unf_pop_sp", 32'(bus.ram_read_address), 32'd15);
`endif
    set_in(PUSH, W'('h42), 1'b0, 1'b0);
    tick();
    set_in(REPL2, W'('h99), 1'b0, 1'b0);
    #1;
    check("unf_repl_we", 32'(bus.ram_write_enable), 32'd0);
    tick();
`ifdef STACK_GUARD_EN
    check("unf_repl_flag", 32'(bus.underflow), 32'd1);
    check("unf_repl_depth", 32'(bus.depth), 32'd1);
    check("unf_repl_top", 32'(bus.top), 32'h42);
    // Error in the same cycle as clear_errors keeps the flag set
    set_in(REPL2, W'('h77), 1'b1, 1'b0);
    tick();
    check("unf_clr_race", 32'(bus.underflow), 32'd1);
    check("unf_clr_top", 32'(bus.top), 32'h42);
`else
    check("unf_repl_depth", 32'(bus.depth), 32'd0);
    check("unf_repl_top", 32'(bus.top), 32'h99);
    check("unf_repl_sp", 32'(bus.ram_read_address), 32'd15);
`endif

    // Reset overriding a push mid-sequence
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      set_in(PUSH, W'(i), 1'b0, 1'b0);
      tick();
    end
    check("mid_pre_depth", 32'(bus.depth), 32'd3);
    set_in(PUSH, W'(4), 1'b0, 1'b1);
    #1;
    check("mid_we", 32'(bus.ram_write_enable), 32'd0);
    tick();
    check("mid_depth", 32'(bus.depth), 32'd0);
    check("mid_sp", 32'(bus.ram_read_address), 32'd0);
    check("mid_top", 32'(bus.top), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 300; i++) rand_cycle(70);
    for (int i = 0; i < 300; i++) rand_cycle(20);
    for (int i = 0; i < 400; i++) rand_cycle(45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
Sequencer for one `stack` RAM instance: owns the stack pointer, the cached top-of-stack register and the occupancy count. It translates per-cycle stack ops from the core decode (push, pop, binary-op replace) into the RAM's read/write port signals. It exposes T (top) and N (next) to the ALU, plus empty/full status and optional guard flags. One instance per data stack and one per return stack.

Parameters:
DEPTH, 4, RAM address width. RAM holds 2**DEPTH entries; total capacity is 2**DEPTH+1 including the top register.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
op  input  2  stack op: 00 NOP, 01 PUSH, 10 POP, 11 REPL2 (consume T and N, produce one)
din  input  `WIDTH  value loaded into T on PUSH and REPL2
clear_errors  input  1  clears sticky error flags
top  output  `WIDTH  T, the top-of-stack register
next  output  `WIDTH  N, equal to ram_read_data
depth  output  DEPTH+1  number of valid entries, 0..2**DEPTH+1
empty  output  1  depth==0
full  output  1  depth==2**DEPTH+1
overflow  output  1  sticky, PUSH attempted while full
underflow  output  1  sticky, POP with depth==0 or REPL2 with depth<2
ram_read_address  output  DEPTH  to stack.read_address, always equals sp
ram_read_data  input  `WIDTH  from stack.read_data (asynchronous read)
ram_write_enable  output  1  to stack.write_enable
ram_write_address  output  DEPTH  to stack.write_address
ram_write_data  output  `WIDTH  to stack.write_data

Behaviour:
- State: sp[DEPTH-1:0], top_q[`WIDTH-1:0], count[DEPTH:0], ovf_q, unf_q.
- Reset (sync, reset=1 at edge): sp=0, top=0, count=0, overflow=0, underflow=0. While reset is high, ram_write_enable=0. Reset overrides any op in the same cycle, including mid-sequence.
- RAM write outputs are combinational from op and state. ram_write_enable=1 only for a legal PUSH. ram_write_address=sp+1 (mod 2**DEPTH). ram_write_data=top.
- PUSH: RAM[sp+1]<=top, sp<=sp+1, top<=din, count<=count+1.
- POP: top<=ram_read_data (RAM[sp]), sp<=sp-1, count<=count-1.
- REPL2: top<=din, sp<=sp-1, count<=count-1. No RAM write. din is the ALU result of T op N.
- NOP: no change.
- Latency: top, next and depth reflect an op on the edge that executes it. next is valid in the same cycle as the new sp because the RAM read is asynchronous. Back-to-back PUSH,POP returns the pushed-over value in T with no bubble.
- Push from empty writes the stale top into RAM. This is harmless because count marks that slot invalid.
- sp arithmetic wraps modulo 2**DEPTH. count never wraps; it is bounded by the guard rules below.
- clear_errors=1 at an edge zeroes both flags. If an error event occurs in the same cycle, the error wins and the flag stays set.

Optional Feature:
STACK_GUARD_EN
- Defined: an illegal op (PUSH when full, POP when empty, REPL2 when depth<2) is suppressed. There is no state change and ram_write_enable=0. The matching sticky flag is set.
- Not defined: every op executes and sp wraps. count saturates at 0 and 2**DEPTH+1 instead of going out of range. overflow and underflow are tied to 0, and clear_errors is ignored.

Test Plan:
- Reset -> top=0, depth=0, empty=1, full=0, flags=0, ram_write_enable=0.
- PUSH 0x11, 0x22, 0x33, then POP, POP -> after the pushes top=0x33 and next=0x22 with depth=3. After the pops top=0x11, depth=1. RAM[1]=0x00, RAM[2]=0x11.
- PUSH 5, PUSH 7, REPL2 din=12 -> top=12, depth=1, and no RAM write occurs on the REPL2 cycle.
- With guard, DEPTH=4: 17 PUSHes give full=1. The 18th PUSH gives overflow=1, depth stays 17, top is unchanged and ram_write_enable=0. Then clear_errors -> overflow=0.
- With guard: POP at depth 0, and REPL2 at depth 1 -> underflow=1 and state unchanged. Without guard, the same POP sets sp=15 with depth held at 0.
- Assert reset on the cycle of a PUSH at depth 3 -> the next cycle shows depth=0, sp=0, top=0, and no RAM write.
